// File: rtl/weight_bias_loader_if.sv
// Host word stream plus the broadcast weight/bias bus driven by the loader.
// Valid/ready: a host word transfers on a rising edge where s_valid and s_ready are both high;
// s_data must be stable while s_valid is high, s_ready never depends on s_valid, and the bus
// side has no ready (every beat is a single-cycle valid pulse that the tagged neuron captures).
interface weight_bias_loader_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        weightValid;
  logic        biasValid;
  logic [31:0] weightValue;
  logic [31:0] biasValue;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;

  modport master (
    input  s_data, s_valid,
    output s_ready, weightValid, biasValid, weightValue, biasValue,
           config_layer_num, config_neuron_num
  );

  modport slave (
    output s_data, s_valid,
    input  s_ready, weightValid, biasValid, weightValue, biasValue,
           config_layer_num, config_neuron_num
  );
endinterface

// File: rtl/weight_bias_loader.sv
// Replays a flat host word stream as per-neuron weight beats followed by one bias beat,
// tagging every beat with the layer and neuron that must capture it.
module weight_bias_loader #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          cfg_layer,
  input  logic [CNT_WIDTH-1:0] cfg_neurons,
  input  logic [CNT_WIDTH-1:0] cfg_weights,
  weight_bias_loader_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_B = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [31:0]          layer_q;
  logic [CNT_WIDTH-1:0] neurons_q;
  logic [CNT_WIDTH-1:0] weights_q;
  logic [CNT_WIDTH-1:0] neuron_cnt;
  logic [CNT_WIDTH-1:0] weight_cnt;
  logic                 hs;
  logic                 cfg_bad;
  logic                 start_ok;
  logic                 last_weight;
  logic                 last_neuron;

  assign bus.s_ready = (state != IDLE);
  assign busy        = (state != IDLE);
  assign state_dbg   = state;
  assign hs          = bus.s_valid & bus.s_ready;
  assign cfg_bad     = (cfg_neurons == '0) || (cfg_weights == '0);
  assign start_ok    = (state == IDLE) && start && !cfg_bad;
  assign last_weight = (weight_cnt == weights_q - CNT_WIDTH'(1));
  assign last_neuron = (neuron_cnt == neurons_q - CNT_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = LOAD_W;
      LOAD_W:  if (hs && last_weight) state_next = LOAD_B;
      LOAD_B:  if (hs) state_next = last_neuron ? IDLE : LOAD_W;
      default: state_next = IDLE;
    endcase
  end

  // Job configuration and position counters; start outside IDLE never reaches here.
  always_ff @(posedge clk) begin
    if (rst) begin
      layer_q    <= '0;
      neurons_q  <= '0;
      weights_q  <= '0;
      neuron_cnt <= '0;
      weight_cnt <= '0;
    end else if (start_ok) begin
      layer_q    <= cfg_layer;
      neurons_q  <= cfg_neurons;
      weights_q  <= cfg_weights;
      neuron_cnt <= '0;
      weight_cnt <= '0;
    end else if (hs && state == LOAD_W) begin
      weight_cnt <= last_weight ? '0 : weight_cnt + CNT_WIDTH'(1);
    end else if (hs && state == LOAD_B && !last_neuron) begin
      neuron_cnt <= neuron_cnt + CNT_WIDTH'(1);
    end
  end

  // Registered bus: the beat, its value and its tags all appear the cycle after the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.weightValid       <= 1'b0;
      bus.biasValid         <= 1'b0;
      bus.weightValue       <= '0;
      bus.biasValue         <= '0;
      bus.config_layer_num  <= '0;
      bus.config_neuron_num <= '0;
      done                  <= 1'b0;
      cfg_err               <= 1'b0;
    end else begin
      bus.weightValid <= hs && (state == LOAD_W);
      bus.biasValid   <= hs && (state == LOAD_B);
      done            <= hs && (state == LOAD_B) && last_neuron;
      cfg_err         <= (state == IDLE) && start && cfg_bad;
      if (hs && state == LOAD_W) bus.weightValue <= bus.s_data;
      if (hs && state == LOAD_B) bus.biasValue   <= bus.s_data;
      if (hs) begin
        bus.config_layer_num  <= layer_q;
        bus.config_neuron_num <= 32'(neuron_cnt);
      end
    end
  end

endmodule

// File: tb/tb_weight_bias_loader.sv
// Bench for weight_bias_loader: random host traffic against a stream-order model of the bus.
module tb_weight_bias_loader;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   cfg_layer;
  logic [CW-1:0] cfg_neurons;
  logic [CW-1:0] cfg_weights;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic [1:0]    state_dbg;

  weight_bias_loader_if bus ();

  weight_bias_loader #(.CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_layer   (cfg_layer),
    .cfg_neurons (cfg_neurons),
    .cfg_weights (cfg_weights),
    .bus         (bus.master),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // beat = {is_bias, layer, neuron, data}
  logic [96:0] exp_q[$];
  logic [96:0] beat_q[$];
  int          beat_cyc_q[$];
  int          hs_q[$];
  int          done_cyc_q[$];
  int          both_cnt = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always @(negedge clk) begin
    if (bus.weightValid || bus.biasValid) begin
      beat_q.push_back({bus.biasValid, bus.config_layer_num, bus.config_neuron_num,
                        bus.biasValid ? bus.biasValue : bus.weightValue});
      beat_cyc_q.push_back(cyc);
    end
    if (bus.weightValid && bus.biasValid) both_cnt++;
    if (done) done_cyc_q.push_back(cyc);
  end

  // reference model: word i of a job goes to neuron i/(W+1); the last word of each group is the bias
  function automatic void model_job(input logic [31:0] layer, input int n, input int w,
                                    input logic [31:0] base);
    for (int i = 0; i < n * (w + 1); i++)
      exp_q.push_back({(i % (w + 1)) == w, layer, 32'(i / (w + 1)), base + 32'(i)});
  endfunction

  // driver tasks
  task automatic clear_logs();
    exp_q.delete();
    beat_q.delete();
    beat_cyc_q.delete();
    hs_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic start_job(input logic [31:0] layer, input int n, input int w);
    cfg_layer   = layer;
    cfg_neurons = CW'(n);
    cfg_weights = CW'(w);
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic drive_words(input int cnt, input logic [31:0] base, input int pct,
                             output int sent);
    int budget;
    budget = cnt * 40 + 50;
    sent   = 0;
    while (sent < cnt && budget > 0) begin
      bus.s_valid = ($urandom_range(99) < pct);
      bus.s_data  = base + 32'(sent);
      if (bus.s_valid && bus.s_ready) begin
        hs_q.push_back(cyc + 1);
        sent++;
      end
      budget--;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
    cfg_layer = '0; cfg_neurons = '0; cfg_weights = '0;
    idle(3);
    n_cmp++;
    if ({bus.s_ready, bus.weightValid, bus.biasValid, busy, done, cfg_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.s_ready, bus.weightValid, bus.biasValid, busy, done, cfg_err});
    end
    n_cmp++;
    if ({bus.weightValue, bus.biasValue, bus.config_layer_num, bus.config_neuron_num} !== 128'b0) begin
      n_fail++;
      $display("FAIL reset_values: got %h %h %h %h expected all 0", bus.weightValue,
               bus.biasValue, bus.config_layer_num, bus.config_neuron_num);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic(input int pct, input string tag);
    int sent;
    clear_logs();
    model_job(32'd1, 2, 3, 32'h10);
    start_job(32'd1, 2, 3);
    n_cmp++;
    if ({busy, bus.s_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL %s_busy_after_start: got %b expected 11", tag, {busy, bus.s_ready});
    end
    drive_words(8, 32'h10, pct, sent);
    idle(3);
    n_cmp++;
    if (beat_q.size() !== 8 || sent !== 8) begin
      n_fail++;
      $display("FAIL %s_count: got %0d beats (%0d sent) expected 8", tag, beat_q.size(), sent);
    end
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      n_cmp++;
      if (beat_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_beat[%0d]: got %h expected %h", tag, i, beat_q[i], exp_q[i]);
      end
      n_cmp++;
      if (i < hs_q.size() && beat_cyc_q[i] !== hs_q[i]) begin
        n_fail++;
        $display("FAIL %s_latency[%0d]: beat cycle %0d expected %0d", tag, i, beat_cyc_q[i], hs_q[i]);
      end
    end
    n_cmp++;
    if (done_cyc_q.size() !== 1 || beat_cyc_q.size() == 0 ||
        done_cyc_q[0] !== beat_cyc_q[beat_cyc_q.size()-1]) begin
      n_fail++;
      $display("FAIL %s_done: got %0d done pulses expected 1 with last bias", tag, done_cyc_q.size());
    end
    n_cmp++;
    if ({bus.weightValue, bus.biasValue, busy} !== {32'h16, 32'h17, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_hold: got w=%h b=%h busy=%b expected w=16 b=17 busy=0", tag,
               bus.weightValue, bus.biasValue, busy);
    end
  endtask

  task automatic test_full_scale();
    int sent;
    logic [31:0] base;
    clear_logs();
    base = $urandom;
    model_job(32'd2, 30, 784, base);
    start_job(32'd2, 30, 784);
    drive_words(23550, base, 100, sent);
    idle(3);
    n_cmp++;
    if (beat_q.size() !== 23550) begin
      n_fail++;
      $display("FAIL full_count: got %0d expected 23550", beat_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      n_cmp++;
      if (beat_q[i] !== exp_q[i] || beat_cyc_q[i] !== hs_q[i]) begin
        n_fail++;
        $display("FAIL full_beat[%0d]: got %h @%0d expected %h @%0d", i, beat_q[i],
                 beat_cyc_q[i], exp_q[i], hs_q[i]);
      end
    end
    n_cmp++;
    if (beat_q.size() == 0 || beat_q[beat_q.size()-1] !== {1'b1, 32'd2, 32'd29, base + 32'd23549}) begin
      n_fail++;
      $display("FAIL full_last_bias: got %h expected bias to neuron 29 = %h",
               beat_q.size() ? beat_q[beat_q.size()-1] : 97'b0, base + 32'd23549);
    end
    n_cmp++;
    if (done_cyc_q.size() !== 1) begin
      n_fail++;
      $display("FAIL full_done: got %0d pulses expected 1", done_cyc_q.size());
    end
  endtask

  task automatic test_reset_mid_job();
    int sent;
    clear_logs();
    model_job(32'd1, 2, 3, 32'h10);
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    start_job(32'd1, 2, 3);
    drive_words(5, 32'h10, 100, sent);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.s_ready, bus.weightValid, bus.biasValid, busy, done, cfg_err, bus.weightValue,
         bus.biasValue, bus.config_layer_num, bus.config_neuron_num} !== 134'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got ready=%b busy=%b w=%h b=%h layer=%h neuron=%h expected all 0",
               bus.s_ready, busy, bus.weightValue, bus.biasValue, bus.config_layer_num,
               bus.config_neuron_num);
    end
    rst = 1'b0;
    idle(2);
    n_cmp++;
    if (beat_q.size() !== 5 || done_cyc_q.size() !== 0) begin
      n_fail++;
      $display("FAIL midrst_beats: got %0d beats %0d done expected 5 beats 0 done",
               beat_q.size(), done_cyc_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      n_cmp++;
      if (beat_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midrst_beat[%0d]: got %h expected %h", i, beat_q[i], exp_q[i]);
      end
    end
    test_basic(100, "rerun");
  endtask

  task automatic test_illegal_start();
    int sent;
    clear_logs();
    start_job(32'd1, 0, 3);
    n_cmp++;
    if ({cfg_err, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL err_n0: got cfg_err,busy=%b expected 10", {cfg_err, busy});
    end
    @(negedge clk);
    n_cmp++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse_width: got %b expected 0", cfg_err);
    end
    start_job(32'd1, 4, 0);
    n_cmp++;
    if ({cfg_err, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL err_w0: got cfg_err,busy=%b expected 10", {cfg_err, busy});
    end
    idle(3);
    n_cmp++;
    if (beat_q.size() !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_no_beats: got %0d beats busy=%b expected 0 beats busy=0", beat_q.size(), busy);
    end
    clear_logs();
    model_job(32'd1, 2, 3, 32'h10);
    start_job(32'd1, 2, 3);
    fork
      drive_words(8, 32'h10, 100, sent);
      begin
        idle(3);
        start_job(32'd3, 5, 5);
      end
    join
    idle(3);
    n_cmp++;
    if (beat_q.size() !== 8 || done_cyc_q.size() !== 1) begin
      n_fail++;
      $display("FAIL ignore_count: got %0d beats %0d done expected 8 beats 1 done",
               beat_q.size(), done_cyc_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      n_cmp++;
      if (beat_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ignore_beat[%0d]: got %h expected %h", i, beat_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent;
    clear_logs();
    model_job(32'd1, 2, 3, 32'h20);
    model_job(32'd3, 1, 1, 32'h30);
    start_job(32'd1, 2, 3);
    drive_words(8, 32'h20, 100, sent);
    n_cmp++;
    if ({done, busy, bus.biasValid} !== 3'b101) begin
      n_fail++;
      $display("FAIL b2b_done_cycle: got done,busy,biasValid=%b expected 101", {done, busy, bus.biasValid});
    end
    start_job(32'd3, 1, 1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b expected 1", busy);
    end
    drive_words(2, 32'h30, 100, sent);
    idle(3);
    n_cmp++;
    if (beat_q.size() !== 10 || done_cyc_q.size() !== 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d beats %0d done expected 10 beats 2 done",
               beat_q.size(), done_cyc_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
      n_cmp++;
      if (beat_q[i] !== exp_q[i] || (i < hs_q.size() && beat_cyc_q[i] !== hs_q[i])) begin
        n_fail++;
        $display("FAIL b2b_beat[%0d]: got %h @%0d expected %h", i, beat_q[i], beat_cyc_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (done_cyc_q.size() == 2 && beat_cyc_q.size() == 10 && done_cyc_q[1] !== beat_cyc_q[9]) begin
      n_fail++;
      $display("FAIL b2b_second_done: got cycle %0d expected %0d", done_cyc_q[1], beat_cyc_q[9]);
    end
  endtask

  task automatic test_exclusive_beats();
    n_cmp++;
    if (both_cnt !== 0) begin
      n_fail++;
      $display("FAIL exclusive_beats: got %0d overlapping cycles expected 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic(100, "basic");
    test_basic(50, "gaps");
    test_basic(30, "gaps_sparse");
    test_reset_mid_job();
    test_illegal_start();
    test_back_to_back();
    test_full_scale();
    test_exclusive_beats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_bias_loader.md
# weight_bias_loader

Initiator side of the neuron weight/bias load interface. Accepts a flat stream of 32-bit words from the host/DMA and replays them as `weightValid`/`biasValid` beats, with `config_layer_num`/`config_neuron_num` tagging each beat so that exactly one neuron captures it. Sits between the host configuration port and the broadcast weight bus shared by all neurons of all layers.

## Interface

Parameters:
- `CNT_WIDTH`, 16, width of the neuron-count and weight-count fields and internal counters.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a load job; honoured only in IDLE.
- `cfg_layer`  in  32  layer number for the job, latched on accepted `start`.
- `cfg_neurons`  in  CNT_WIDTH  neurons in the layer (N), latched on `start`.
- `cfg_weights`  in  CNT_WIDTH  weights per neuron (W), latched on `start`.
- `s_data`  in  32  host word.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  loader accepts `s_data` this cycle.
- `weightValid`  out  1  weight beat on bus.
- `biasValid`  out  1  bias beat on bus.
- `weightValue`  out  32  weight word.
- `biasValue`  out  32  bias word.
- `config_layer_num`  out  32  target layer.
- `config_neuron_num`  out  32  target neuron, zero-extended counter, numbering from 0.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse, job complete.
- `cfg_err`  out  1  one-cycle pulse, `start` rejected due to N=0 or W=0.

## Operation

- Stream order per job: neuron 0: W weights, then 1 bias; neuron 1: same; … neuron N-1. Total N*(W+1) words.
- FSM states: IDLE, LOAD_W, LOAD_B.
  - IDLE: on `start` with N≠0 and W≠0, latch config, clear neuron count and weight count, go to LOAD_W. On `start` with N=0 or W=0: pulse `cfg_err`, stay IDLE.
  - LOAD_W: on handshake (`s_valid & s_ready`), emit weight beat; weight count +1; when it reaches W-1 on the handshake, clear it and go to LOAD_B.
  - LOAD_B: on handshake, emit bias beat; if neuron count = N-1, go to IDLE and pulse `done`; else neuron count +1 and go to LOAD_W.
- `s_ready` = 1 in LOAD_W or LOAD_B, combinational from state only (no dependence on `s_valid`).
- `busy` = state ≠ IDLE.
- `start` outside IDLE is ignored and has no effect on config or counters.
- `weightValue`/`biasValue` hold their last value when not valid. `config_*` are updated only with a beat.
- Counters are unsigned CNT_WIDTH. No wrap is possible within a legal job.

## Timing

- Reset: state IDLE; `s_ready`, `weightValid`, `biasValid`, `busy`, `done`, `cfg_err` = 0; `weightValue`, `biasValue`, `config_layer_num`, `config_neuron_num` = 0; counters 0.
- Reset mid-job aborts immediately, with no `done` pulse. Words already emitted stay in neuron memories, and the next job starts from neuron 0.
- All bus outputs are registered. A handshake at edge k drives the valid, value, `config_layer_num` and `config_neuron_num` together during cycle k+1, valid for one cycle.
- Throughput is one word per cycle with `s_valid` held high. `s_valid` gaps produce gaps on the bus, with no beat duplication.
- `start` accepted at edge k: `busy`=1 and `s_ready`=1 from cycle k+1.
- Last bias handshake at edge k: `biasValid`=1 and `done`=1 in cycle k+1; `busy`=0 and `s_ready`=0 in cycle k+1. A new `start` can be accepted at edge k+1.
- `cfg_err` is asserted in the cycle after the rejected `start`.
- Weight and bias beats are never simultaneous.

## Test plan

- Basic job: `cfg_layer`=1, N=2, W=3, `s_data`=0x10..0x17 streamed continuously. Expected bus sequence: W 0x10,0x11,0x12 to neuron 0; B 0x13 to neuron 0; W 0x14,0x15,0x16 to neuron 1; B 0x17 to neuron 1. `config_layer_num`=1 throughout. `done` coincides with B 0x17. Exactly 8 beats.
- Backpressure/gaps: same job with `s_valid` toggled randomly. Bus order and tags are identical to the basic job, each beat appears exactly one cycle after its handshake, and no duplicates occur.
- Full-scale job: `cfg_layer`=2, N=30, W=784, with an incrementing data pattern. The 23550 beats have correct neuron tags. Neuron 29's bias equals word 23549.
- Reset mid-job: assert `rst` after 5 handshakes of the basic job. Expected: all outputs 0, no `done`. Rerunning the basic job then yields the full correct sequence.
- Illegal/ignored start: `start` with N=0 gives a `cfg_err` pulse, `busy` stays 0, and no beats occur. `start` with layer=3 mid-job is ignored: tags stay at 1 and the job completes normally.
- Back-to-back: a second `start` (layer=3, N=1, W=1) in the cycle of the first job's `done` is accepted. It produces W then B beats to layer 3, neuron 0, with `done` pulsed again.
